// File: rtl/id_scoreboard_ctrl_if.sv
// Decode-side issue/retire bundle for the register scoreboard.
// master drives decode, execute-ready, writeback and flush; slave reports issue state.
interface id_scoreboard_ctrl_if #(
  parameter int CNTW = 3
);
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            id_reg_write;
  logic            ex_ready;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic [CNTW-1:0] flush_keep;
  logic            stall;
  logic            issue;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic [CNTW-1:0] inflight;
  logic            full;
  logic            wb_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_uses_rs1, id_uses_rs2, id_reg_write,
    output ex_ready, wb_valid, wb_rd,
    output flush, flush_keep,
    input  stall, issue, hazard_rs1, hazard_rs2,
    input  inflight, full, wb_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_uses_rs1, id_uses_rs2, id_reg_write,
    input  ex_ready, wb_valid, wb_rd,
    input  flush, flush_keep,
    output stall, issue, hazard_rs1, hazard_rs2,
    output inflight, full, wb_err
  );
endinterface

// File: rtl/id_scoreboard_ctrl.sv
// In-order writer scoreboard and issue gate for the decode stage.
// Define WB_BYPASS_EN to let the retiring head stop hazarding in its retire cycle.
module id_scoreboard_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input logic clk,
  input logic rst,
  id_scoreboard_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0]   ptr_t;
  typedef logic [CNTW-1:0] cnt_t;

  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  cnt_t             cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [4:0]       ent_rd_q  [DEPTH];
  logic [4:0]       ent_rd_d  [DEPTH];
  logic             ent_wen_q [DEPTH];
  logic             ent_wen_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  logic pop;
  logic live;
  logic match1, match2;
  logic haz1, haz2;
  logic stall, issue;
  cnt_t cnt_pop;
  cnt_t keep;
  ptr_t off;

  always_comb begin
    pop    = bus.wb_valid & (cnt_q != '0);
    live   = 1'b0;
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live = vld_q[i] & ent_wen_q[i];
`ifdef WB_BYPASS_EN
      // register file writes first, so the retiring head is already visible
      if (pop && (ptr_t'(i) == rd_ptr_q)) live = 1'b0;
`endif
      if (live && (ent_rd_q[i] == bus.id_rs1)) match1 = 1'b1;
      if (live && (ent_rd_q[i] == bus.id_rs2)) match2 = 1'b1;
    end
    haz1 = rst & bus.id_valid & bus.id_uses_rs1
         & (bus.id_rs1 != 5'd0) & match1;
    haz2 = rst & bus.id_valid & bus.id_uses_rs2
         & (bus.id_rs2 != 5'd0) & match2;
    stall = rst & bus.id_valid
          & (haz1 | haz2 | ~bus.ex_ready
             | (full_q & ~bus.wb_valid) | bus.flush);
    issue = rst & bus.id_valid & ~stall;
  end

  always_comb begin
    err_d = err_q;
    if (bus.wb_valid) begin
      if (cnt_q == '0) err_d = 1'b1;
      else if (ent_wen_q[rd_ptr_q]
               && (ent_rd_q[rd_ptr_q] != bus.wb_rd))
        err_d = 1'b1;
    end

    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    cnt_pop  = cnt_q - cnt_t'(pop);
    keep     = (bus.flush_keep > cnt_pop) ? cnt_pop
                                          : bus.flush_keep;

    ent_rd_d  = ent_rd_q;
    ent_wen_d = ent_wen_q;
    if (bus.flush) begin
      // truncate younger entries relative to the post-retire head
      wr_ptr_d = ptr_t'(cnt_t'(rd_ptr_d) + keep);
      cnt_d    = keep;
    end else begin
      wr_ptr_d = wr_ptr_q + ptr_t'(issue);
      cnt_d    = cnt_pop + cnt_t'(issue);
      if (issue) begin
        ent_rd_d[wr_ptr_q]  = bus.id_rd;
        ent_wen_d[wr_ptr_q] = bus.id_reg_write
                            & (bus.id_rd != 5'd0);
      end
    end
    full_d = (cnt_d == cnt_t'(DEPTH));

    off   = '0;
    vld_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = ptr_t'(i) - rd_ptr_d;
      vld_d[i] = (cnt_t'(off) < cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]  <= 5'd0;
        ent_wen_q[i] <= 1'b0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      ent_rd_q  <= ent_rd_d;
      ent_wen_q <= ent_wen_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.issue      = issue;
  assign bus.hazard_rs1 = haz1;
  assign bus.hazard_rs2 = haz2;
  assign bus.inflight   = cnt_q;
  assign bus.full       = full_q;
  assign bus.wb_err     = err_q;
endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Directed and random checks of id_scoreboard_ctrl against a queue model.
// Build with +define+WB_BYPASS_EN to check the bypass variant.
module tb_id_scoreboard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_scoreboard_ctrl_if #(.CNTW(3)) bus ();

  id_scoreboard_ctrl #(.DEPTH(4), .CNTW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0] rd;
    bit         wen;
  } ent_t;

  ent_t mq[$];
  bit   merr;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(logic [4:0] rs, bit skip_head);
    for (int i = 0; i < mq.size(); i++) begin
      if (skip_head && i == 0) continue;
      if (mq[i].wen && mq[i].rd == rs) return 1'b1;
    end
    return 1'b0;
  endfunction

  // check this cycle's outputs, clock once, advance the model
  task automatic tick();
    bit h1, h2, st, is, skip;
    int keep;
    if (!rst) begin
      mq.delete();
      merr = 1'b0;
    end
    #1;
    skip = 1'b0;
`ifdef WB_BYPASS_EN
    skip = bus.wb_valid && mq.size() > 0;
`endif
    h1 = rst && bus.id_valid && bus.id_uses_rs1
      && bus.id_rs1 != 0 && pending(bus.id_rs1, skip);
    h2 = rst && bus.id_valid && bus.id_uses_rs2
      && bus.id_rs2 != 0 && pending(bus.id_rs2, skip);
    st = rst && bus.id_valid && (h1 || h2 || !bus.ex_ready
      || (mq.size() == 4 && !bus.wb_valid) || bus.flush);
    is = rst && bus.id_valid && !st;
    chk("hazard_rs1", 8'(bus.hazard_rs1), 8'(h1));
    chk("hazard_rs2", 8'(bus.hazard_rs2), 8'(h2));
    chk("stall", 8'(bus.stall), 8'(st));
    chk("issue", 8'(bus.issue), 8'(is));
    chk("inflight", 8'(bus.inflight), 8'(mq.size()));
    chk("full", 8'(bus.full), 8'(mq.size() == 4));
    chk("wb_err", 8'(bus.wb_err), 8'(merr));
    @(posedge clk);
    if (rst) begin
      if (bus.wb_valid) begin
        if (mq.size() == 0) merr = 1'b1;
        else begin
          if (mq[0].wen && mq[0].rd != bus.wb_rd) merr = 1'b1;
          void'(mq.pop_front());
        end
      end
      if (bus.flush) begin
        keep = int'(bus.flush_keep);
        while (mq.size() > keep) void'(mq.pop_back());
      end else if (is) begin
        mq.push_back('{bus.id_rd,
                       bus.id_reg_write && bus.id_rd != 0});
      end
    end
    #1;
  endtask

  task automatic drv(bit v, logic [4:0] rs1, bit u1,
                     logic [4:0] rs2, bit u2,
                     logic [4:0] rd, bit rw);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_uses_rs1  = u1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs2  = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
  endtask

  task automatic wb(bit v, logic [4:0] rd);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
  endtask

  task automatic drain();
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 8 && mq.size() > 0; n++) begin
      wb(1, mq[0].rd);
      tick();
    end
    wb(0, 0);
  endtask

  initial begin
    drv(1, 5, 1, 0, 0, 0, 0);
    bus.ex_ready   = 1'b0;
    wb(0, 0);
    bus.flush      = 1'b0;
    bus.flush_keep = 3'd0;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();

    // reset mid-stream with three in flight
    for (int i = 1; i <= 3; i++) begin
      drv(1, 0, 0, 0, 0, 5'(i), 1);
      tick();
    end
    rst = 1'b0;
    drv(1, 5, 1, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();

    // RAW stall until rd=7 retires
    drain();
    drv(1, 0, 0, 0, 0, 7, 1);
    tick();
    drv(1, 7, 1, 0, 0, 9, 1);
    tick();
    tick();
    wb(1, 7);
    tick();
    wb(0, 0);
    tick();
    tick();

    // x0 writer never hazards
    drain();
    drv(1, 0, 0, 0, 0, 0, 1);
    tick();
    drv(1, 0, 1, 0, 1, 3, 0);
    tick();

    // full boundary and pointer wrap
    drain();
    for (int i = 1; i <= 4; i++) begin
      drv(1, 0, 0, 0, 0, 5'(i), 1);
      tick();
    end
    drv(1, 0, 1, 0, 0, 5, 1);
    tick();
    wb(1, mq[0].rd);
    tick();
    for (int i = 0; i < 10; i++) begin
      wb(1, mq[0].rd);
      drv(1, 0, 0, 0, 0, 5'(10 + i % 6), 1);
      tick();
    end
    wb(0, 0);
    drv(1, mq[3].rd, 1, mq[0].rd, 1, 0, 0);
    tick();

    // flush truncation
    drain();
    for (int i = 3; i <= 5; i++) begin
      drv(1, 0, 0, 0, 0, 5'(i), 1);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    bus.flush      = 1'b1;
    bus.flush_keep = 3'd1;
    tick();
    bus.flush = 1'b0;
    bus.ex_ready = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      drv(1, 5'(i), 1, 0, 0, 0, 0);
      tick();
    end
    bus.ex_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b1;
    wb(1, 3);
    tick();
    bus.flush = 1'b0;
    wb(0, 0);
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      bus.ex_ready = $urandom_range(0, 4) != 0;
      if (mq.size() > 0 && $urandom_range(0, 2) == 0)
        wb(1, mq[0].rd);
      else
        wb(0, 0);
      bus.flush      = $urandom_range(0, 9) == 0;
      bus.flush_keep = 3'($urandom_range(0, 7));
      tick();
    end
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;

    // retire errors are sticky until reset
    drain();
    wb(1, 0);
    tick();
    wb(0, 0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drv(1, 0, 0, 0, 0, 9, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    wb(1, 10);
    tick();
    wb(0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/id_scoreboard_ctrl.md
Name: id_scoreboard_ctrl

Overview:
- Issue/hazard controller for the decode stage of the RV32I pipeline.
- Tracks in-flight register writers in an in-order queue, from issue out of decode to retirement at writeback.
- Stalls decode when a source register read would return stale data.
- Gates issue on downstream readiness and discards squashed writers on branch/jump flush.

Parameters:
DEPTH, 4, maximum in-flight instructions between issue and writeback (power of 2, >=2)
CNTW, 3, width of occupancy count; equals clog2(DEPTH)+1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
id_valid  in  1  decode holds a valid instruction
id_rs1  in  5  source register 1 (instruction[19:15])
id_rs2  in  5  source register 2 (instruction[24:20])
id_rd  in  5  destination register (instruction[11:7])
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_reg_write  in  1  instruction writes rd (reg_write from opcode decoder)
ex_ready  in  1  execute stage accepts an instruction this cycle
wb_valid  in  1  one instruction retires at writeback this cycle
wb_rd  in  5  rd of retiring instruction
flush  in  1  branch/jump redirect; squash younger in-flight entries
flush_keep  in  CNTW  entries to retain, oldest first, after this cycle's retire
stall  out  1  decode must hold its instruction
issue  out  1  instruction leaves decode this cycle
hazard_rs1  out  1  rs1 matches a pending writer
hazard_rs2  out  1  rs2 matches a pending writer
inflight  out  CNTW  current queue occupancy
full  out  1  inflight == DEPTH
wb_err  out  1  sticky: retire with an empty queue, or wb_rd not equal to head rd

Behaviour:
- Queue storage: circular buffer of DEPTH entries, each holding {rd[4:0], wen}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Reset (rst=0, asynchronous): pointers=0, inflight=0, wb_err=0, all entry valid bits cleared.
- Reset output values: stall=0, issue=0, hazard_rs1=0, hazard_rs2=0, full=0.
- Reset mid-operation discards all in-flight entries immediately.
- Hazard detection (combinational):
  - hazard_rsN = id_valid & id_usesN & (id_rsN != 0) & (a live entry has wen=1 and rd == id_rsN).
  - x0 never hazards.
- stall = id_valid & (hazard_rs1 | hazard_rs2 | ~ex_ready | (full & ~wb_valid) | flush).
- issue = id_valid & ~stall.
- Zero added latency: issue asserts in the same cycle its conditions hold.
- Push on issue: the entry {id_rd, id_reg_write & (id_rd != 0)} is written at the write pointer.
  - Every issued instruction is pushed, including stores and branches, so queue order matches retirement order.
- Pop on wb_valid: the head entry is removed.
  - If inflight==0, or head rd != wb_rd for an entry with wen=1, wb_err sets and holds until reset.
  - A pop with an empty queue leaves the pointers unchanged.
- Simultaneous pop and push when full: allowed. Occupancy is unchanged and both pointers advance.
- Flush:
  - Evaluate in this order: pop (if wb_valid), then truncate.
  - Truncation sets the write pointer to read pointer + flush_keep; occupancy becomes flush_keep.
  - flush_keep greater than the post-pop occupancy saturates to that occupancy.
  - flush blocks issue in the same cycle (flush wins over issue).
- inflight and full are registered, derived from the pointer state after each clock edge.

Optional Feature:
WB_BYPASS_EN
- Defined: the entry being popped this cycle (wb_valid=1, head) is excluded from hazard matching, because the register file writes first in the same cycle. A dependent instruction issues in the retire cycle.
- Undefined: the head entry still matches during its retire cycle. The dependent instruction stalls one additional cycle and issues the cycle after retirement.

Test Plan:
1. Reset sequence: rst=0 mid-stream with inflight=3 -> all outputs 0 immediately; after rst=1, an instruction with rs1=5 and ex_ready=1 -> issue=1 the same cycle.
2. RAW stall: issue rd=7, then an instruction with rs1=7 -> stall=1, hazard_rs1=1 until wb_valid with wb_rd=7.
   - Bypass defined: issue in the retire cycle.
   - Bypass undefined: issue one cycle later.
3. Writes to x0 never hazard: issue rd=0 reg_write=1, then rs1=0 and rs2=0 -> no stall.
4. Full boundary (DEPTH=4):
   - Four issues with no retire -> full=1; next instruction stalls.
   - Same cycle with wb_valid=1 -> issue=1 and inflight stays 4.
   - Pointers wrap correctly over 10 consecutive issues.
5. Flush: inflight=3 (rd 3, 4, 5), flush=1, flush_keep=1, no wb -> inflight=1; rs1=4 and rs1=5 no longer hazard, rs1=3 still hazards.
   - With wb_valid=1 in the same cycle -> inflight=0.
6. Error: wb_valid with inflight=0, or head rd=9 retired with wb_rd=10 -> wb_err=1 and stays 1 until rst=0.
